// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel format and prefetch FSM state type.
package vga_pkg;

   localparam int unsigned H_ACT     = 640;
   localparam int unsigned V_ACT     = 480;
   localparam int unsigned FRAME_PIX = H_ACT * V_ACT;

   // RGB565 field layout: red [15:11], green [10:5], blue [4:0]
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      XFER  = 2'd2,
      DRAIN = 2'd3
   } pf_state_e;

endpackage

// File: rtl/vga_pix_prefetch_if.sv
// Frame-store burst read bus between the prefetcher (master) and memory (slave).
interface vga_pix_prefetch_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned MEM_AW = 24
);
   logic              rd_req;
   logic [MEM_AW-1:0] rd_addr;
   logic [8:0]        rd_len;
   logic              rd_ack;
   logic              rd_data_vld;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output rd_req, rd_addr, rd_len,
      input  rd_ack, rd_data_vld, rd_data
   );

   modport slave (
      input  rd_req, rd_addr, rd_len,
      output rd_ack, rd_data_vld, rd_data
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO on an inferred RAM with registered read data and flush.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);
   localparam int unsigned DEPTH = 2**AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   // level never exceeds DEPTH, so its MSB alone marks full
   assign full    = level_q[AW];
   assign empty   = (level_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = rdata_q;
   assign level   = level_q;

   // Next pointer/level; flush clears everything and overrides push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Storage array, no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   // Registered read port; holds its value when nothing is popped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rdata_q <= '0;
      else if (do_pop) rdata_q <= mem_q[rd_ptr_q];
   end

   // Pointer and occupancy state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/vga_pix_prefetch.sv
// Pixel prefetch buffer: bursts frame-store data into a FIFO ahead of the VGA controller.
module vga_pix_prefetch #(
   parameter int unsigned      DATA_W    = 16,
   parameter int unsigned      FIFO_AW   = 10,
   parameter int unsigned      BURST_LEN = 256,
   parameter int unsigned      FRAME_PIX = vga_pkg::FRAME_PIX,
   parameter int unsigned      MEM_AW    = 24,
   parameter logic [MEM_AW-1:0] BASE_ADDR = '0,
   parameter logic [DATA_W-1:0] UNDER_PIX = '0
) (
   input  logic                vga_clk,
   input  logic                sys_rst_n,
   input  logic                vsync,
   input  logic                pix_data_req,
   output logic [DATA_W-1:0]   pix_data,
   vga_pix_prefetch_if.master  rd_bus,
   output logic [FIFO_AW:0]    fifo_level,
   output logic                underflow,
   output logic                overflow
);
   import vga_pkg::*;

   localparam int unsigned       RC_W       = $clog2(FRAME_PIX + 1);
   localparam logic [FIFO_AW:0]  FILL_LIMIT = (FIFO_AW+1)'((2**FIFO_AW) - BURST_LEN);

   pf_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [8:0]        len_q, len_d;
   logic [8:0]        beat_q, beat_d;
   logic [RC_W-1:0]   req_cnt_q, req_cnt_d;
   logic              armed_q, armed_d;
   logic              under_q, under_d;
   logic              over_q, over_d;
   logic              usel_q, usel_d;
   logic [2:0]        vs_q;

   logic              frame_start;
   logic              beat_push;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic [FIFO_AW:0]  level;
   logic [31:0]       remain;
   logic [8:0]        len_next;

   assign frame_start = vs_q[2] & ~vs_q[1];
   assign beat_push   = (state_q == XFER) & rd_bus.rd_data_vld;
   assign remain      = FRAME_PIX - 32'(req_cnt_q);
   assign len_next    = (remain < BURST_LEN) ? 9'(remain) : 9'(BURST_LEN);

   sync_fifo #(.WIDTH(DATA_W), .AW(FIFO_AW)) u_fifo (
      .clk   (vga_clk),
      .rst_n (sys_rst_n),
      .flush (frame_start),
      .push  (beat_push),
      .wdata (rd_bus.rd_data),
      .pop   (pix_data_req),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign pix_data       = usel_q ? UNDER_PIX : fifo_rdata;
   assign fifo_level     = level;
   assign underflow      = under_q;
   assign overflow       = over_q;
   assign rd_bus.rd_req  = req_q;
   assign rd_bus.rd_addr = addr_q;
   assign rd_bus.rd_len  = len_q;

   // Burst request FSM; a frame start overrides normal progress and
   // diverts any burst already accepted by memory into DRAIN
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      req_cnt_d = req_cnt_q;
      armed_d   = armed_q;
      case (state_q)
         IDLE: begin
            if (armed_q && (32'(req_cnt_q) < FRAME_PIX) && (level <= FILL_LIMIT)) begin
               len_d   = len_next;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (rd_bus.rd_ack) begin
               req_d     = 1'b0;
               beat_d    = len_q;
               req_cnt_d = req_cnt_q + RC_W'(len_q);
               addr_d    = addr_q + MEM_AW'(len_q);
               state_d   = XFER;
            end
         end
         XFER, DRAIN: begin
            if (rd_bus.rd_data_vld) begin
               beat_d = beat_q - 9'd1;
               if (beat_q == 9'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (frame_start) begin
         armed_d   = 1'b1;
         req_cnt_d = '0;
         addr_d    = BASE_ADDR;
         req_d     = 1'b0;
         case (state_q)
            REQ:         state_d = rd_bus.rd_ack ? DRAIN : IDLE;
            XFER, DRAIN: state_d = (beat_d == '0) ? IDLE : DRAIN;
            default:     state_d = IDLE;
         endcase
      end
   end

   // Read-side flags: underflow select for pix_data and sticky error bits
   always_comb begin
      usel_d  = usel_q;
      under_d = under_q;
      over_d  = over_q;
      if (frame_start) begin
         under_d = 1'b0;
         over_d  = 1'b0;
      end else begin
         if (pix_data_req) begin
            usel_d = fifo_empty;
            if (fifo_empty) under_d = 1'b1;
         end
         if (beat_push && fifo_full) over_d = 1'b1;
      end
   end

   // vsync double-register plus one more stage for edge detection
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) vs_q <= '1;
      else            vs_q <= {vs_q[1:0], vsync};
   end

   // Control and status registers
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         addr_q    <= BASE_ADDR;
         len_q     <= '0;
         beat_q    <= '0;
         req_cnt_q <= '0;
         armed_q   <= 1'b0;
         under_q   <= 1'b0;
         over_q    <= 1'b0;
         usel_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         req_cnt_q <= req_cnt_d;
         armed_q   <= armed_d;
         under_q   <= under_d;
         over_q    <= over_d;
         usel_q    <= usel_d;
      end
   end
endmodule

// File: tb/tb_vga_pix_prefetch.sv
// Directed testbench for vga_pix_prefetch with a short frame (1300 pixels).
module tb_vga_pix_prefetch;

   localparam int unsigned FRAME_PIX = 1300;

   logic        vga_clk      = 1'b0;
   logic        sys_rst_n    = 1'b0;
   logic        vsync        = 1'b1;
   logic        pix_data_req = 1'b0;
   logic [15:0] pix_data;
   logic [10:0] fifo_level;
   logic        underflow;
   logic        overflow;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   vga_pix_prefetch_if #(.DATA_W(16), .MEM_AW(24)) rd_bus ();

   vga_pix_prefetch #(
      .DATA_W    (16),
      .FIFO_AW   (10),
      .BURST_LEN (256),
      .FRAME_PIX (FRAME_PIX),
      .MEM_AW    (24),
      .BASE_ADDR (24'h0),
      .UNDER_PIX (16'h0000)
   ) dut (
      .vga_clk      (vga_clk),
      .sys_rst_n    (sys_rst_n),
      .vsync        (vsync),
      .pix_data_req (pix_data_req),
      .pix_data     (pix_data),
      .rd_bus       (rd_bus),
      .fifo_level   (fifo_level),
      .underflow    (underflow),
      .overflow     (overflow)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Wait (bounded) for rd_req, then check the request fields
   task automatic wait_req(input int unsigned addr, input int unsigned len);
      int unsigned n = 0;
      while (!rd_bus.rd_req && n < 8) begin
         @(negedge vga_clk);
         n++;
      end
      chk("rd_req_seen", 32'(rd_bus.rd_req), 1);
      chk("rd_addr", 32'(rd_bus.rd_addr), addr);
      chk("rd_len", 32'(rd_bus.rd_len), len);
   endtask

   // Acknowledge the pending request and deliver len beats valued first..
   task automatic serve(input int unsigned len, input int unsigned first);
      rd_bus.rd_ack = 1'b1;
      @(negedge vga_clk);
      rd_bus.rd_ack = 1'b0;
      chk("rd_req_drop", 32'(rd_bus.rd_req), 0);
      for (int unsigned i = 0; i < len; i++) begin
         rd_bus.rd_data_vld = 1'b1;
         rd_bus.rd_data     = 16'(first + i);
         @(negedge vga_clk);
      end
      rd_bus.rd_data_vld = 1'b0;
   endtask

   // Hold pix_data_req for n cycles; each popped word must be first+i
   task automatic pop(input int unsigned n, input int unsigned first);
      for (int unsigned i = 0; i < n; i++) begin
         pix_data_req = 1'b1;
         @(negedge vga_clk);
         chk("pop_data", 32'(pix_data), first + i);
      end
      pix_data_req = 1'b0;
   endtask

   task automatic no_req(input int unsigned cycles);
      repeat (cycles) begin
         @(negedge vga_clk);
         chk("no_rd_req", 32'(rd_bus.rd_req), 0);
      end
   endtask

   task automatic vsync_fall();
      vsync = 1'b0;
      repeat (3) @(negedge vga_clk);
      vsync = 1'b1;
   endtask

   initial begin
      rd_bus.rd_ack      = 1'b0;
      rd_bus.rd_data_vld = 1'b0;
      rd_bus.rd_data     = '0;
      repeat (3) @(negedge vga_clk);
      sys_rst_n = 1'b1;

      // Reset state
      chk("rst_pix_data", 32'(pix_data), 0);
      chk("rst_rd_req", 32'(rd_bus.rd_req), 0);
      chk("rst_rd_addr", 32'(rd_bus.rd_addr), 0);
      chk("rst_rd_len", 32'(rd_bus.rd_len), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_overflow", 32'(overflow), 0);
      no_req(10);

      // First frame: request at base, fields stable while unacknowledged
      vsync_fall();
      wait_req(0, 256);
      repeat (3) @(negedge vga_clk);
      chk("hold_rd_req", 32'(rd_bus.rd_req), 1);
      chk("hold_rd_addr", 32'(rd_bus.rd_addr), 0);
      chk("hold_rd_len", 32'(rd_bus.rd_len), 256);
      serve(256, 1);
      chk("level_256", 32'(fifo_level), 256);

      // Back-to-back bursts until the FIFO is too full for another
      wait_req(256, 256);
      serve(256, 257);
      wait_req(512, 256);
      serve(256, 513);
      wait_req(768, 256);
      serve(256, 769);
      chk("level_full", 32'(fifo_level), 1024);
      no_req(20);
      chk("no_overflow", 32'(overflow), 0);

      // Pops return data in order; draining to 768 re-enables requests
      pop(5, 1);
      chk("level_1019", 32'(fifo_level), 1019);
      pop(251, 6);
      chk("level_768", 32'(fifo_level), 768);
      wait_req(1024, 256);
      serve(256, 1025);
      pop(256, 257);
      // Last burst of the frame is shortened to the remaining 20 pixels
      wait_req(1280, 20);
      serve(20, 1281);
      chk("level_788", 32'(fifo_level), 788);
      pop(788, 513);
      chk("level_empty", 32'(fifo_level), 0);
      no_req(20);
      chk("no_underflow_yet", 32'(underflow), 0);

      // Request on empty FIFO
      pix_data_req = 1'b1;
      @(negedge vga_clk);
      pix_data_req = 1'b0;
      chk("under_pix", 32'(pix_data), 0);
      chk("underflow_set", 32'(underflow), 1);
      chk("under_level", 32'(fifo_level), 0);

      // New frame clears underflow and restarts at base address
      vsync_fall();
      wait_req(0, 256);
      chk("underflow_clr", 32'(underflow), 0);
      rd_bus.rd_ack = 1'b1;
      @(negedge vga_clk);
      rd_bus.rd_ack = 1'b0;
      for (int unsigned i = 0; i < 10; i++) begin
         rd_bus.rd_data_vld = 1'b1;
         rd_bus.rd_data     = 16'(1 + i);
         @(negedge vga_clk);
      end
      chk("level_10", 32'(fifo_level), 10);
      // Simultaneous push and pop at level 10
      for (int unsigned i = 0; i < 90; i++) begin
         rd_bus.rd_data_vld = 1'b1;
         rd_bus.rd_data     = 16'(11 + i);
         pix_data_req       = 1'b1;
         @(negedge vga_clk);
         chk("pushpop_data", 32'(pix_data), 1 + i);
      end
      pix_data_req = 1'b0;
      chk("pushpop_level", 32'(fifo_level), 10);

      // vsync falls after 100 of 256 beats: the rest must be discarded
      vsync = 1'b0;
      for (int unsigned i = 0; i < 156; i++) begin
         rd_bus.rd_data_vld = 1'b1;
         rd_bus.rd_data     = 16'(101 + i);
         @(negedge vga_clk);
         if (i == 150) begin
            chk("drain_no_req", 32'(rd_bus.rd_req), 0);
            chk("drain_level", 32'(fifo_level), 0);
         end
      end
      rd_bus.rd_data_vld = 1'b0;
      vsync = 1'b1;
      wait_req(0, 256);
      chk("post_drain_level", 32'(fifo_level), 0);

      // Asynchronous reset in the middle of a transfer
      rd_bus.rd_ack = 1'b1;
      @(negedge vga_clk);
      rd_bus.rd_ack = 1'b0;
      for (int unsigned i = 0; i < 50; i++) begin
         rd_bus.rd_data_vld = 1'b1;
         rd_bus.rd_data     = 16'(1 + i);
         @(negedge vga_clk);
      end
      rd_bus.rd_data_vld = 1'b0;
      chk("pre_rst_level", 32'(fifo_level), 50);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_pix_data", 32'(pix_data), 0);
      chk("arst_rd_req", 32'(rd_bus.rd_req), 0);
      chk("arst_rd_addr", 32'(rd_bus.rd_addr), 0);
      chk("arst_rd_len", 32'(rd_bus.rd_len), 0);
      chk("arst_level", 32'(fifo_level), 0);
      chk("arst_underflow", 32'(underflow), 0);
      chk("arst_overflow", 32'(overflow), 0);
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      no_req(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_pix_prefetch.md
Name: vga_pix_prefetch

Overview:
- Single-clock pixel prefetch buffer directly upstream of the VGA timing controller, in the vga_clk domain.
- Fetches RGB565 frame data from the frame-store read port in bursts and holds it in an internal FIFO.
- Answers the controller's pix_data_req with pix_data exactly one cycle later, so data lands on the controller's rgb_valid window.
- Restarts at the frame base address on every vsync assertion.

Parameters:
- DATA_W, 16, pixel width (RGB565).
- FIFO_AW, 10, FIFO address width; depth = 2**FIFO_AW = 1024 words.
- BURST_LEN, 256, maximum words per read burst; must be ≤ 2**FIFO_AW.
- FRAME_PIX, 307200, pixels per frame (640x480).
- MEM_AW, 24, frame-store word address width.
- BASE_ADDR, 0, frame-store word address of pixel (0,0).
- UNDER_PIX, 16'h0000, value driven on pix_data when the FIFO is empty.

Ports:
- vga_clk, in, 1, pixel clock; the only clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- vsync, in, 1, active-low vertical sync from the timing controller.
- pix_data_req, in, 1, the controller requests the next pixel.
- pix_data, out, DATA_W, pixel value, registered.
- rd_req, out, 1, burst read request, held high until acknowledged.
- rd_addr, out, MEM_AW, burst start word address; stable while rd_req is high.
- rd_len, out, 9, burst length in words; stable while rd_req is high.
- rd_ack, in, 1, one-cycle acceptance of rd_req.
- rd_data_vld, in, 1, qualifies rd_data.
- rd_data, in, DATA_W, read data beat.
- fifo_level, out, FIFO_AW+1, current FIFO occupancy.
- underflow, out, 1, sticky per frame: a request was made while the FIFO was empty.
- overflow, out, 1, sticky per frame: a beat arrived while the FIFO was full.

Behaviour:
Reset values:
- pix_data=0; rd_req=0; rd_addr=BASE_ADDR; rd_len=0.
- fifo_level=0; underflow=0; overflow=0.
- FIFO pointers 0; state IDLE; words-requested counter req_cnt=0.

Frame start:
- vsync is registered twice; frame_start is the cycle the second stage sees a 1->0 transition.
- On frame_start: flush the FIFO (pointers and level to 0), req_cnt=0, rd_addr=BASE_ADDR, underflow=0, overflow=0.
- If a burst is in flight at frame_start, go to DRAIN; otherwise go to IDLE.

State machine:
- IDLE: if req_cnt < FRAME_PIX and free space ≥ BURST_LEN (free space = 2**FIFO_AW - fifo_level):
  - load rd_len = min(BURST_LEN, FRAME_PIX - req_cnt);
  - assert rd_req;
  - go to REQ.
- REQ: hold rd_req, rd_addr and rd_len until rd_ack. In the cycle rd_ack is high:
  - drop rd_req next cycle;
  - beat counter = rd_len;
  - req_cnt += rd_len; rd_addr += rd_len;
  - go to XFER.
- XFER: each rd_data_vld writes rd_data into the FIFO and decrements the beat counter. When the counter reaches 0, go to IDLE; a new request can be raised the next cycle.
- DRAIN: count the remaining beats and discard them without writing the FIFO, then go to IDLE.
  - frame_start in DRAIN re-flushes but stays in DRAIN.
  - frame_start while in REQ with rd_ack not yet seen: drop rd_req and go to IDLE.
  - frame_start in the same cycle as rd_ack: the burst counts as in flight, go to DRAIN.

Read side:
- pix_data_req at cycle N with the FIFO non-empty: pop, and pix_data holds that word at N+1.
- pix_data_req with the FIFO empty: pix_data=UNDER_PIX at N+1, underflow=1, no pop, level unchanged.
- No request: pix_data holds its last value.

FIFO rules:
- Simultaneous push and pop: level unchanged, both pointers advance.
- Push while full (not reachable in legal operation): beat dropped, overflow=1.
- Pointers are FIFO_AW bits and wrap modulo depth; level is FIFO_AW+1 bits.
- A pop in the frame_start cycle is ignored; the flush wins.

Address arithmetic:
- rd_addr is MEM_AW bits and wraps modulo 2**MEM_AW; no saturation.

Decomposition:
- Shared package vga_pkg holds H/V timing constants (H_ACT, V_ACT), FRAME_PIX derived as H_ACT*V_ACT, RGB565 field positions, and the state enum {IDLE, REQ, XFER, DRAIN}.
- One sub-module, sync_fifo: single-clock, parameterised width/depth, with push, pop, full, empty and level. Implement it on inferred block RAM with registered read data.

Test Plan:
- Reset, then vsync falls -> rd_req=1, rd_addr=0, rd_len=256 within 4 cycles. Ack plus 256 beats -> fifo_level=256; next request rd_addr=256.
- Requests kept back-to-back with an instant responder -> bursts stop once fifo_level > 768. After 1200 bursts req_cnt=307200 and no further rd_req until the next vsync fall.
- FIFO preloaded with 1..5, pix_data_req held for 5 cycles -> pix_data=1,2,3,4,5 on cycles N+1..N+5. A 6th request gives pix_data=16'h0000 and underflow=1.
- vsync falls after 100 of 256 beats -> 156 beats discarded, fifo_level=0. Next rd_addr=0 and underflow clears.
- Push and pop in the same cycle at level 10 -> level stays 10, data order preserved.
- sys_rst_n asserted mid-XFER -> all outputs return to their reset values asynchronously. After release, no rd_req until a vsync fall.
